// File: rtl/ft_pkg.sv
// ---------------------------------------------------------------------------
// ft_pkg
// Shared types and default constants for the fault-tolerant block monitor.
// Holds the per-replica health state enum, the default values for the
// monitor parameters, and a small population-count helper used by the
// arbitration logic.
// ---------------------------------------------------------------------------
package ft_pkg;

    // Health of one voter replica, as tracked by its error counter.
    typedef enum logic [1:0] {
        FT_OK      = 2'd0,
        FT_SUSPECT = 2'd1,
        FT_BROKEN  = 2'd2
    } ft_blk_state_e;

    localparam int unsigned FT_ERR_THRESH_DEF   = 4;
    localparam int unsigned FT_CNT_W_DEF        = 8;
    localparam int unsigned FT_DECAY_PERIOD_DEF = 256;

    // Number of set bits in a three-replica flag vector.
    function automatic logic [1:0] ft_popcount3(input logic [2:0] flags);
        return {1'b0, flags[0]} + {1'b0, flags[1]} + {1'b0, flags[2]};
    endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// ---------------------------------------------------------------------------
// cv32e40p_ft_err_counter
// Error counter and health FSM for a single voter replica.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   clear_i      - synchronous clear back to FT_OK with a zero count
//   err_i        - a valid mismatch sample flagged this replica
//   decay_i      - decay tick; a suspect replica's count drops by one
//   grant_i      - arbiter allows this replica to become FT_BROKEN now
//   state_o      - current health state
//   cnt_o        - current error count (saturating)
//   thresh_hit_o - this cycle's counted error brings the count to threshold
// ---------------------------------------------------------------------------
module cv32e40p_ft_err_counter
    import ft_pkg::*;
#(
    parameter int unsigned ERR_THRESH = FT_ERR_THRESH_DEF,
    parameter int unsigned CNT_W      = FT_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             err_i,
    input  logic             decay_i,
    input  logic             grant_i,
    output ft_blk_state_e    state_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             thresh_hit_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    ft_blk_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             count_en;

    // A broken replica is frozen, so its errors are simply not counted.
    // The incremented value saturates so the counter never wraps to zero.
    assign count_en     = err_i && (state_q != FT_BROKEN);
    assign cnt_inc      = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    assign thresh_hit_o = count_en && (32'(cnt_inc) >= ERR_THRESH);

    // Health FSM and counter. Clear beats everything else. A counted error
    // takes priority over a decay tick, which is how a same-cycle error
    // cancels the decrement. The break itself is only taken when the top
    // level grants it, since at most one replica may be declared broken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FT_OK;
            cnt_q   <= '0;
        end else if (clear_i) begin
            state_q <= FT_OK;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                FT_OK: begin
                    if (count_en) begin
                        cnt_q   <= cnt_inc;
                        state_q <= grant_i ? FT_BROKEN : FT_SUSPECT;
                    end
                end
                FT_SUSPECT: begin
                    if (count_en) begin
                        cnt_q <= cnt_inc;
                        if (grant_i) begin
                            state_q <= FT_BROKEN;
                        end
                    end else if (decay_i) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= FT_OK;
                        end
                    end
                end
                FT_BROKEN: begin
                    state_q <= FT_BROKEN;
                end
                default: begin
                    state_q <= FT_OK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/cv32e40p_ft_block_monitor.sv
// ---------------------------------------------------------------------------
// cv32e40p_ft_block_monitor
// Watches the per-replica mismatch flags of a triple-redundant voter,
// counts errors per replica and declares at most one replica broken.
// The broken mask is fed back to the voter so it can ignore that replica.
//
// Ports:
//   clk            - clock, rising edge
//   rst_n          - asynchronous active-low reset
//   valid_i        - voter result sample valid this cycle
//   block_err_i    - per-replica mismatch flags from the voter
//   err_detected_i - voter detected a mismatch
//   err_corrected_i- voter corrected the mismatch
//   clear_i        - synchronous clear of all monitor state
//   broken_block_o - registered one-hot (or zero) broken-replica mask
//   err_cnt_o      - per-replica error counts
//   irq_o          - one-cycle pulse when a replica is newly broken
//   fatal_o        - sticky unrecoverable condition
//
// Build option: define CV32E40P_FT_DECAY_EN to enable the decay timer that
// slowly forgives errors on suspect replicas. Without it counts only grow.
// ---------------------------------------------------------------------------
module cv32e40p_ft_block_monitor
    import ft_pkg::*;
#(
    parameter int unsigned ERR_THRESH   = FT_ERR_THRESH_DEF,
    parameter int unsigned CNT_W        = FT_CNT_W_DEF,
    parameter int unsigned DECAY_PERIOD = FT_DECAY_PERIOD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [2:0]            block_err_i,
    input  logic                  err_detected_i,
    input  logic                  err_corrected_i,
    input  logic                  clear_i,
    output logic [2:0]            broken_block_o,
    output logic [2:0][CNT_W-1:0] err_cnt_o,
    output logic                  irq_o,
    output logic                  fatal_o
);

    if (ERR_THRESH < 1) begin : g_bad_thresh
        $error("ERR_THRESH must be at least 1");
    end
    if (DECAY_PERIOD < 2) begin : g_bad_period
        $error("DECAY_PERIOD must be at least 2");
    end

    ft_blk_state_e blk_state [3];
    logic [2:0]    sample_err;
    logic [2:0]    thresh_hit;
    logic [2:0]    grant;
    logic          conflict;
    logic          uncorrected;
    logic          decay_tick;
    logic          irq_q;
    logic          fatal_q;

    assign sample_err  = valid_i ? block_err_i : 3'b000;
    assign uncorrected = valid_i && err_detected_i && !err_corrected_i;

    for (genvar i = 0; i < 3; i++) begin : g_replica
        cv32e40p_ft_err_counter #(
            .ERR_THRESH (ERR_THRESH),
            .CNT_W      (CNT_W)
        ) u_err_counter (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear_i      (clear_i),
            .err_i        (sample_err[i]),
            .decay_i      (decay_tick),
            .grant_i      (grant[i]),
            .state_o      (blk_state[i]),
            .cnt_o        (err_cnt_o[i]),
            .thresh_hit_o (thresh_hit[i])
        );

        assign broken_block_o[i] = (blk_state[i] == FT_BROKEN);
    end

    // Break arbitration. A single replica reaching threshold while nothing
    // is broken yet gets granted. A second broken replica, or two reaching
    // threshold together, means the voter can no longer out-vote the fault,
    // so nothing is granted and the condition is escalated to fatal.
    always_comb begin
        grant    = 3'b000;
        conflict = 1'b0;
        if (thresh_hit != 3'b000) begin
            if ((broken_block_o != 3'b000) || (ft_popcount3(thresh_hit) > 2'd1)) begin
                conflict = 1'b1;
            end else begin
                grant = thresh_hit;
            end
        end
    end

    // Interrupt pulse and sticky fatal flag. The interrupt fires once, in
    // the same cycle the broken mask first shows the new replica. Fatal
    // collects both arbitration conflicts and uncorrectable voter errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= 1'b0;
            fatal_q <= 1'b0;
        end else if (clear_i) begin
            irq_q   <= 1'b0;
            fatal_q <= 1'b0;
        end else begin
            irq_q   <= (grant != 3'b000);
            fatal_q <= fatal_q || conflict || uncorrected;
        end
    end

    assign irq_o   = irq_q;
    assign fatal_o = fatal_q;

`ifdef CV32E40P_FT_DECAY_EN
    localparam int unsigned TmrW = (DECAY_PERIOD > 2) ? $clog2(DECAY_PERIOD) : 1;

    logic [TmrW-1:0] decay_tmr_q;

    assign decay_tick = (decay_tmr_q == TmrW'(DECAY_PERIOD - 1));

    // Free-running decay timer; each wrap forgives one error on every
    // suspect replica. Clear restarts it so the period is measured afresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decay_tmr_q <= '0;
        end else if (clear_i || decay_tick) begin
            decay_tmr_q <= '0;
        end else begin
            decay_tmr_q <= decay_tmr_q + TmrW'(1);
        end
    end
`else
    assign decay_tick = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_ft_block_monitor.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_ft_block_monitor
// Self-checking bench for the fault-tolerant block monitor. Instance dut_a
// uses the default threshold/width with a short decay period; instance
// dut_b uses a 2-bit counter to show saturation below threshold. Both see
// the same stimulus; table rows only describe dut_a.
// ---------------------------------------------------------------------------
module tb_cv32e40p_ft_block_monitor;

    localparam int unsigned PERIOD_A = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid;
    logic [2:0]      block_err;
    logic            err_det;
    logic            err_corr;
    logic            clear;

    logic [2:0]      broken_a;
    logic [2:0][7:0] cnt_a;
    logic            irq_a;
    logic            fatal_a;

    logic [2:0]      broken_b;
    logic [2:0][1:0] cnt_b;
    logic            irq_b;
    logic            fatal_b;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic        valid;
        logic [2:0]  err;
        logic        det;
        logic        corr;
        logic        clr;
        logic [31:0] expv;
    } vec_t;

    typedef struct {
        int          row;
        logic [31:0] expv;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   rowNum = 0;

    cv32e40p_ft_block_monitor #(
        .ERR_THRESH   (4),
        .CNT_W        (8),
        .DECAY_PERIOD (PERIOD_A)
    ) dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid),
        .block_err_i     (block_err),
        .err_detected_i  (err_det),
        .err_corrected_i (err_corr),
        .clear_i         (clear),
        .broken_block_o  (broken_a),
        .err_cnt_o       (cnt_a),
        .irq_o           (irq_a),
        .fatal_o         (fatal_a)
    );

    cv32e40p_ft_block_monitor #(
        .ERR_THRESH   (4),
        .CNT_W        (2),
        .DECAY_PERIOD (1024)
    ) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_i         (valid),
        .block_err_i     (block_err),
        .err_detected_i  (err_det),
        .err_corrected_i (err_corr),
        .clear_i         (clear),
        .broken_block_o  (broken_b),
        .err_cnt_o       (cnt_b),
        .irq_o           (irq_b),
        .fatal_o         (fatal_b)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic v, input logic [2:0] e, input logic d,
                                input logic c, input logic cl, input logic [2:0] eb,
                                input int c0, input int c1, input int c2,
                                input logic ei, input logic ef);
        vec_t r;
        r.valid = v;
        r.err   = e;
        r.det   = d;
        r.corr  = c;
        r.clr   = cl;
        r.expv  = {3'b000, eb, 8'(c0), 8'(c1), 8'(c2), ei, ef};
        return r;
    endfunction

    function automatic logic [31:0] actualA();
        return {3'b000, broken_a, cnt_a[0], cnt_a[1], cnt_a[2], irq_a, fatal_a};
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setInputs(input logic v, input logic [2:0] e, input logic d,
                             input logic c, input logic cl);
        valid     = v;
        block_err = e;
        err_det   = d;
        err_corr  = c;
        clear     = cl;
    endtask

    // Pop the oldest expectation and compare dut_a's outputs against it.
    task automatic checkOutput();
        sb_t s;
        if (sbq.size() == 0) begin
            checkValue("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            s = sbq.pop_front();
            checkValue($sformatf("row%0d", s.row), actualA(), s.expv);
        end
    endtask

    // Drive one sample, queue its expectation, let one edge pass, compare.
    task automatic applyStimulus(input vec_t v);
        setInputs(v.valid, v.err, v.det, v.corr, v.clr);
        sbq.push_back('{rowNum, v.expv});
        rowNum++;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        setInputs(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;

        // Main table: breaking, frozen counts, second replica conflict,
        // uncorrected errors, clear priority, simultaneous threshold.
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 2, 0, 0, 0));
        tbl.push_back(mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 3, 0, 0, 0));
        tbl.push_back(mk(1, 3'b010, 0, 0, 0, 3'b010, 0, 4, 0, 1, 0));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b010, 0, 4, 0, 0, 0));
        tbl.push_back(mk(1, 3'b010, 0, 0, 0, 3'b010, 0, 4, 0, 0, 0));
        tbl.push_back(mk(1, 3'b100, 0, 0, 0, 3'b010, 0, 4, 1, 0, 0));
        tbl.push_back(mk(1, 3'b100, 0, 0, 0, 3'b010, 0, 4, 2, 0, 0));
        tbl.push_back(mk(1, 3'b100, 0, 0, 0, 3'b010, 0, 4, 3, 0, 0));
        tbl.push_back(mk(1, 3'b100, 0, 0, 0, 3'b010, 0, 4, 4, 0, 1));
        tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b010, 0, 4, 4, 0, 1));
        tbl.push_back(mk(0, 3'b000, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'b001, 1, 1, 0, 3'b000, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'b000, 1, 0, 0, 3'b000, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 3'b000, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3'b111, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'b111, 1, 0, 1, 3'b000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'b011, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3'b011, 0, 0, 0, 3'b000, 2, 2, 0, 0, 0));
        tbl.push_back(mk(1, 3'b011, 0, 0, 0, 3'b000, 3, 3, 0, 0, 0));
        tbl.push_back(mk(1, 3'b011, 0, 0, 0, 3'b000, 4, 4, 0, 0, 1));
        tbl.push_back(mk(0, 3'b000, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkValue("reset_a", actualA(), 32'd0);
        checkValue("reset_b", {23'd0, broken_b, cnt_b, irq_b, fatal_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] applying %0d table rows", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
        end

        // Asynchronous reset in the middle of counting.
        applyStimulus(mk(1, 3'b010, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0));
        applyStimulus(mk(1, 3'b110, 1, 0, 0, 3'b000, 0, 2, 1, 0, 1));
        #2;
        rst_n = 1'b0;
        setInputs(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        #1;
        checkValue("async_reset", actualA(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Decay: two errors on replica 0, then two full decay periods idle.
        applyStimulus(mk(0, 3'b000, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 3'b001, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0));
        applyStimulus(mk(1, 3'b001, 0, 0, 0, 3'b000, 2, 0, 0, 0, 0));
        setInputs(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        repeat (2 * PERIOD_A) @(posedge clk);
        #1;
`ifdef CV32E40P_FT_DECAY_EN
        checkValue("decay_cnt0", 32'(cnt_a[0]), 32'd0);
        applyStimulus(mk(1, 3'b001, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0));
        applyStimulus(mk(1, 3'b001, 0, 0, 0, 3'b000, 2, 0, 0, 0, 0));
        applyStimulus(mk(1, 3'b001, 0, 0, 0, 3'b000, 3, 0, 0, 0, 0));
        applyStimulus(mk(1, 3'b001, 0, 0, 0, 3'b001, 4, 0, 0, 1, 0));
`else
        checkValue("decay_cnt0", 32'(cnt_a[0]), 32'd2);
        applyStimulus(mk(1, 3'b001, 0, 0, 0, 3'b000, 3, 0, 0, 0, 0));
        applyStimulus(mk(1, 3'b001, 0, 0, 0, 3'b001, 4, 0, 0, 1, 0));
        applyStimulus(mk(1, 3'b001, 0, 0, 0, 3'b001, 4, 0, 0, 0, 0));
        applyStimulus(mk(0, 3'b000, 0, 0, 0, 3'b001, 4, 0, 0, 0, 0));
`endif

        // Saturation on the 2-bit instance: stops at 3, never breaks.
        applyStimulus(mk(0, 3'b000, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            setInputs(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            checkValue($sformatf("sat_cnt%0d", i), 32'(cnt_b[0]), (i < 2) ? 32'(i + 1) : 32'd3);
            checkValue($sformatf("sat_state%0d", i), {30'd0, broken_b != 3'b000, irq_b}, 32'd0);
        end
        setInputs(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        checkValue("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cv32e40p_ft_block_monitor.md
CV32E40P_FT_BLOCK_MONITOR -- requirements
Module: cv32e40p_ft_block_monitor

Interface
REQ-001 SHALL have parameter ERR_THRESH, default 4: errors on one replica (range 1..2^CNT_W-1) before that replica is declared broken.
REQ-002 SHALL have parameter CNT_W, default 8: width of each per-replica error counter.
REQ-003 SHALL have parameter DECAY_PERIOD, default 256: number of clk cycles per decay tick (range >=2).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port valid_i, input, 1: voter result sample valid this cycle.
REQ-007 SHALL have port block_err_i, input, [2:0]: per-replica mismatch flags from the voter.
REQ-008 SHALL have port err_detected_i, input, 1: voter detected a mismatch.
REQ-009 SHALL have port err_corrected_i, input, 1: voter corrected the mismatch.
REQ-010 SHALL have port clear_i, input, 1: synchronous clear of all monitor state.
REQ-011 SHALL have port broken_block_o, output, [2:0]: registered broken-replica mask, fed back to the voter's broken_block_i.
REQ-012 SHALL have port err_cnt_o, output, [2:0][CNT_W-1:0]: per-replica counter values.
REQ-013 SHALL have port irq_o, output, 1: one-cycle pulse when a replica is newly declared broken.
REQ-014 SHALL have port fatal_o, output, 1: sticky unrecoverable condition.

Function
REQ-015 SHALL keep one FSM per replica with states FT_OK, FT_SUSPECT, FT_BROKEN.
REQ-016 SHALL sample inputs only when valid_i=1; block_err_i[i] on a non-broken replica increments counter i, saturating at 2^CNT_W-1.
REQ-017 SHALL move FT_OK->FT_SUSPECT on the first counted error.
REQ-018 SHALL move FT_SUSPECT->FT_BROKEN when the post-increment count equals or exceeds ERR_THRESH, provided no replica is already broken.
REQ-019 SHALL set broken_block_o[i] and pulse irq_o in the cycle after the threshold-reaching sample.
REQ-020 SHALL keep FT_BROKEN sticky until clear_i or reset, with counter i frozen and further errors on i ignored.
REQ-021 SHALL allow at most one bit of broken_block_o set.
REQ-022 SHALL handle a second replica reaching threshold (including two replicas in the same cycle) as follows: set fatal_o, leave broken_block_o unchanged, and not pulse irq_o.
REQ-023 SHALL set fatal_o on any valid sample with err_detected_i=1 and err_corrected_i=0.
REQ-024 SHALL have clear_i win over a simultaneous valid error: return all FSMs to FT_OK and zero counters, broken mask, fatal_o and the decay timer.
REQ-025 SHALL make fatal_o sticky until clear_i or reset.

Reset
REQ-026 SHALL, while rst_n=0 (asynchronously, including mid-operation), force broken_block_o=0, err_cnt_o=0, irq_o=0, fatal_o=0, all FSMs to FT_OK, and the decay timer to 0.

Configuration
REQ-027 SHALL, with CV32E40P_FT_DECAY_EN defined, run a timer wrapping at DECAY_PERIOD-1; on each wrap every FT_SUSPECT counter decrements by 1 and the FSM returns to FT_OK when it reaches 0; a same-cycle counted error on that replica cancels that replica's decrement.
REQ-028 SHALL, without CV32E40P_FT_DECAY_EN, omit the timer and keep counters non-decreasing; FT_SUSPECT then exits only via threshold, clear_i or reset.

Structure
REQ-029 SHALL declare the typedef ft_blk_state_e and the default constants for ERR_THRESH, CNT_W and DECAY_PERIOD in ft_pkg.
REQ-030 SHALL implement the per-replica counter and FSM as sub-module cv32e40p_ft_err_counter, instantiated three times; top-level logic covers arbitration, fatal_o, irq_o and the decay timer.

Verification
REQ-031 SHALL cover: 4 valid samples with block_err_i=3'b010 -> err_cnt_o[1]=4, broken_block_o=3'b010 one cycle later, irq_o single pulse.
REQ-032 SHALL cover: replica 1 broken, then 4 errors on replica 2 -> fatal_o=1, broken_block_o stays 3'b010, no irq_o.
REQ-033 SHALL cover: valid_i=1, err_detected_i=1, err_corrected_i=0 -> fatal_o=1 next cycle; clear_i pulse -> all outputs 0.
REQ-034 SHALL cover (DECAY_EN): 2 errors on replica 0, then 2*DECAY_PERIOD idle cycles -> err_cnt_o[0]=0, FSM in FT_OK; without the macro err_cnt_o[0] stays 2.
REQ-035 SHALL cover: clear_i and an error sample in the same cycle -> counters 0; rst_n low mid-count -> outputs 0 immediately.
REQ-036 SHALL cover: ERR_THRESH=4, CNT_W=2 -> count saturates at 3 and replica never breaks.
